// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//
// Memory-access stage of the 6-bit MIPS pipeline, placed directly after the
// EX/MEM register. Non-memory instructions pass to MEM/WB in one cycle.
// Loads and stores are issued to an external data memory over a req/ack
// handshake. EX/MEM is held through stall_o while an access is outstanding.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   - an access that is not acked within TIMEOUT_CYC ACCESS cycles
//               is abandoned. The instruction retires without a register
//               write, and the sticky err_o is set.
//   Undefined - ACCESS waits for ack indefinitely and err_o is tied to 0.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   valid_in                        EX/MEM holds a real instruction
//   RegWriteIN/MemtoRegIN/MemWriteIN  control bits from EX/MEM
//   ALUIN                           ALU result, also the memory address
//   WriteDataIN                     store data
//   WriteRegIN                      destination register
//   stall_o                         hold EX/MEM (drive its enable inverted)
//   mem_req, mem_we                 memory request and write strobe
//   mem_addr, mem_wdata             memory address and write data
//   mem_rdata, mem_ack              read data and single-cycle completion
//   RegWriteOUT/MemtoRegOUT/valid_out  MEM/WB control
//   ReadDataOUT, ALUOUT, WriteRegOUT   MEM/WB data
//   err_o                           sticky timeout error
//
// state  | meaning
// IDLE   | pass-through; a memory op is captured here and stalls one cycle
// ACCESS | request outstanding, waiting for mem_ack (or timeout)

module mem_wb_stage #(
    parameter int DATA_W      = 6,
    parameter int REG_W       = 6,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              RegWriteIN,
    input  logic              MemtoRegIN,
    input  logic              MemWriteIN,
    input  logic [DATA_W-1:0] ALUIN,
    input  logic [DATA_W-1:0] WriteDataIN,
    input  logic [REG_W-1:0]  WriteRegIN,
    output logic              stall_o,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              RegWriteOUT,
    output logic              MemtoRegOUT,
    output logic              valid_out,
    output logic [DATA_W-1:0] ReadDataOUT,
    output logic [DATA_W-1:0] ALUOUT,
    output logic [REG_W-1:0]  WriteRegOUT,
    output logic              err_o
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Request registers: loaded only when leaving IDLE, so they are frozen
    // for the whole ACCESS phase.
    logic [DATA_W-1:0] req_addr_q,  req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              req_we_q,    req_we_d;
    logic              req_rw_q,    req_rw_d;
    logic              req_m2r_q,   req_m2r_d;
    logic [REG_W-1:0]  req_wreg_q,  req_wreg_d;

    // MEM/WB register
    logic              wb_valid_q, wb_valid_d;
    logic              wb_rw_q,    wb_rw_d;
    logic              wb_m2r_q,   wb_m2r_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
    logic [DATA_W-1:0] wb_alu_q,   wb_alu_d;
    logic [REG_W-1:0]  wb_wreg_q,  wb_wreg_d;

    logic mem_op;
    logic stall;
    logic timeout_hit;

    assign mem_op = valid_in & (MemtoRegIN | MemWriteIN);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Fires in the TIMEOUT_CYC-th unacked ACCESS cycle, i.e. the cycle in
    // which the count would reach TIMEOUT_CYC.
    assign timeout_hit = (state_q == S_ACCESS) && !mem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_ACCESS) && !mem_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_we_d    = req_we_q;
        req_rw_d    = req_rw_q;
        req_m2r_d   = req_m2r_q;
        req_wreg_d  = req_wreg_q;
        // MEM/WB defaults to a bubble
        wb_valid_d  = 1'b0;
        wb_rw_d     = 1'b0;
        wb_m2r_d    = 1'b0;
        wb_rdata_d  = '0;
        wb_alu_d    = '0;
        wb_wreg_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall       = 1'b1;
                    state_d     = S_ACCESS;
                    req_addr_d  = ALUIN;
                    req_wdata_d = WriteDataIN;
                    req_we_d    = MemWriteIN;
                    req_rw_d    = RegWriteIN;
                    // a store with MemtoReg also set is treated as a plain store
                    req_m2r_d   = MemtoRegIN & ~MemWriteIN;
                    req_wreg_d  = WriteRegIN;
                end else begin
                    wb_valid_d = valid_in;
                    wb_rw_d    = RegWriteIN;
                    wb_m2r_d   = MemtoRegIN;
                    wb_alu_d   = ALUIN;
                    wb_wreg_d  = WriteRegIN;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = req_rw_q;
                    wb_m2r_d   = req_m2r_q;
                    wb_rdata_d = req_we_q ? '0 : mem_rdata;
                    wb_alu_d   = req_addr_q;
                    wb_wreg_d  = req_wreg_q;
                end else if (timeout_hit) begin
                    // retire without a register write so the pipeline drains
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_m2r_d   = req_m2r_q;
                    wb_alu_d   = req_addr_q;
                    wb_wreg_d  = req_wreg_q;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
            req_rw_q    <= 1'b0;
            req_m2r_q   <= 1'b0;
            req_wreg_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_m2r_q    <= 1'b0;
            wb_rdata_q  <= '0;
            wb_alu_q    <= '0;
            wb_wreg_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_we_q    <= req_we_d;
            req_rw_q    <= req_rw_d;
            req_m2r_q   <= req_m2r_d;
            req_wreg_q  <= req_wreg_d;
            wb_valid_q  <= wb_valid_d;
            wb_rw_q     <= wb_rw_d;
            wb_m2r_q    <= wb_m2r_d;
            wb_rdata_q  <= wb_rdata_d;
            wb_alu_q    <= wb_alu_d;
            wb_wreg_q   <= wb_wreg_d;
        end
    end

    // stall is gated by rst_n so EX/MEM is released while reset is held
    assign stall_o     = stall & rst_n;
    assign mem_req     = (state_q == S_ACCESS);
    assign mem_we      = (state_q == S_ACCESS) & req_we_q;
    assign mem_addr    = req_addr_q;
    assign mem_wdata   = req_wdata_q;

    assign valid_out   = wb_valid_q;
    assign RegWriteOUT = wb_rw_q;
    assign MemtoRegOUT = wb_m2r_q;
    assign ReadDataOUT = wb_rdata_q;
    assign ALUOUT      = wb_alu_q;
    assign WriteRegOUT = wb_wreg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a memory responder with a
// programmable ack latency, a scoreboard of expected MEM/WB retirements, and
// one task per scenario.
module tb_mem_wb_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in, RegWriteIN, MemtoRegIN, MemWriteIN;
    logic [5:0] ALUIN, WriteDataIN, WriteRegIN;
    logic       stall_o, mem_req, mem_we;
    logic [5:0] mem_addr, mem_wdata;
    logic [5:0] mem_rdata;
    logic       mem_ack;
    logic       RegWriteOUT, MemtoRegOUT, valid_out;
    logic [5:0] ReadDataOUT, ALUOUT, WriteRegOUT;
    logic       err_o;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(6), .REG_W(6), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .RegWriteIN(RegWriteIN), .MemtoRegIN(MemtoRegIN), .MemWriteIN(MemWriteIN),
        .ALUIN(ALUIN), .WriteDataIN(WriteDataIN), .WriteRegIN(WriteRegIN),
        .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .RegWriteOUT(RegWriteOUT), .MemtoRegOUT(MemtoRegOUT), .valid_out(valid_out),
        .ReadDataOUT(ReadDataOUT), .ALUOUT(ALUOUT), .WriteRegOUT(WriteRegOUT),
        .err_o(err_o)
    );

    typedef struct {
        logic       rw;
        logic       m2r;
        logic [5:0] alu;
        logic [5:0] wreg;
        logic [5:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int         ack_lat  = 0;     // 0 = never ack
    logic [5:0] rsp_data = 6'd0;
    int         acc_cnt  = 0;

    // Memory responder: ack is raised at the negedge of the ack_lat-th
    // ACCESS cycle and dropped one negedge later (one rising edge wide).
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack   = 1'b0;
            acc_cnt   = 0;
        end else if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = 6'h3F;
            acc_cnt   = 0;
        end else if (mem_req) begin
            acc_cnt++;
            if (ack_lat != 0 && acc_cnt == ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rsp_data;
            end
        end
    end

    // Retirement monitor: every cycle with valid_out is one retired op.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_out === 1'b1) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got alu=%0d wreg=%0d, required no retirement",
                         ALUOUT, WriteRegOUT);
            end else begin
                e = sb.pop_front();
                if ({RegWriteOUT, MemtoRegOUT, ALUOUT, WriteRegOUT, ReadDataOUT} !==
                    {e.rw, e.m2r, e.alu, e.wreg, e.rdata}) begin
                    bad++;
                    $display("FAIL retire_data: got rw=%0b m2r=%0b alu=%0d wreg=%0d rd=%0d, required rw=%0b m2r=%0b alu=%0d wreg=%0d rd=%0d",
                             RegWriteOUT, MemtoRegOUT, ALUOUT, WriteRegOUT, ReadDataOUT,
                             e.rw, e.m2r, e.alu, e.wreg, e.rdata);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        valid_in = 0; RegWriteIN = 0; MemtoRegIN = 0; MemWriteIN = 0;
        ALUIN = 0; WriteDataIN = 0; WriteRegIN = 0;
    endtask

    // Presents one instruction and holds it until the DUT stops stalling.
    // Pushes the expected retirement and reports the observed handshake.
    task automatic send(input logic v, input logic rw, input logic m2r, input logic mw,
                        input logic [5:0] alu, input logic [5:0] wd, input logic [5:0] wreg,
                        input bit timeout,
                        output int stalls, output int reqs, output int wes, output int req_bad);
        exp_t e;
        bit   done;
        @(posedge clk); #1;
        valid_in = v; RegWriteIN = rw; MemtoRegIN = m2r; MemWriteIN = mw;
        ALUIN = alu; WriteDataIN = wd; WriteRegIN = wreg;
        if (v) begin
            e.rw    = timeout ? 1'b0 : rw;
            e.m2r   = m2r & ~mw;
            e.alu   = alu;
            e.wreg  = wreg;
            e.rdata = (m2r && !mw && !timeout) ? rsp_data : 6'd0;
            sb.push_back(e);
        end
        stalls = 0; reqs = 0; wes = 0; req_bad = 0; done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (mem_req) begin
                reqs++;
                if (mem_addr !== alu) req_bad++;
                if (mw && mem_wdata !== wd) req_bad++;
            end
            if (mem_we) wes++;
            if (!stall_o) begin
                done = 1;
                break;
            end
            stalls++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL stall_timeout: stall_o still %0b after 40 cycles, required 0", stall_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; mem_ack = 0; mem_rdata = 0;
        valid_in = 0; RegWriteIN = 0; MemtoRegIN = 0; MemWriteIN = 0;
        ALUIN = 0; WriteDataIN = 0; WriteRegIN = 0;
        #12;
        total++;
        if ({stall_o, mem_req, mem_we, mem_addr, mem_wdata, valid_out, RegWriteOUT,
             MemtoRegOUT, ReadDataOUT, ALUOUT, WriteRegOUT, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%0b stall=%0b valid=%0b alu=%0d, required all 0",
                     mem_req, stall_o, valid_out, ALUOUT);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_alu();
        int st, rq, we, rb;
        send(1, 1, 0, 0, 6'd23, 6'd0, 6'd5, 0, st, rq, we, rb);
        total++;
        if (st !== 0 || rq !== 0) begin
            bad++;
            $display("FAIL alu_nostall: got stalls=%0d reqs=%0d, required 0 0", st, rq);
        end
        // second ALU op right behind, no bubble
        send(1, 0, 0, 0, 6'd63, 6'd0, 6'd1, 0, st, rq, we, rb);
        total++;
        if (st !== 0) begin
            bad++;
            $display("FAIL alu_b2b_nostall: got stalls=%0d, required 0", st);
        end
        idle();
    endtask

    task automatic test_load();
        int st, rq, we, rb;
        ack_lat = 3; rsp_data = 6'd41;
        send(1, 1, 1, 0, 6'd12, 6'd0, 6'd3, 0, st, rq, we, rb);
        total++;
        if (st !== 3) begin
            bad++;
            $display("FAIL load_stall: got stalls=%0d, required 3", st);
        end
        total++;
        if (rq !== 3 || rb !== 0 || we !== 0) begin
            bad++;
            $display("FAIL load_req: got reqs=%0d addr_errs=%0d we=%0d, required 3 0 0", rq, rb, we);
        end
        idle();
    endtask

    task automatic test_store();
        int st, rq, we, rb;
        ack_lat = 1; rsp_data = 6'd50;
        send(1, 1, 0, 1, 6'd7, 6'd9, 6'd2, 0, st, rq, we, rb);
        total++;
        if (st !== 1 || rq !== 1) begin
            bad++;
            $display("FAIL store_stall: got stalls=%0d reqs=%0d, required 1 1", st, rq);
        end
        total++;
        if (we !== 1 || rb !== 0) begin
            bad++;
            $display("FAIL store_we: got we_cycles=%0d data_errs=%0d, required 1 0", we, rb);
        end
        // MemtoReg and MemWrite both set: treated as a store, MemtoRegOUT forced 0
        send(1, 0, 1, 1, 6'd30, 6'd17, 6'd6, 0, st, rq, we, rb);
        total++;
        if (we !== 1 || rb !== 0) begin
            bad++;
            $display("FAIL store_both_we: got we_cycles=%0d data_errs=%0d, required 1 0", we, rb);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int st1, st2, st3, rq1, rq2, rq3, we, rb1, rb2, rb3;
        ack_lat = 1;
        rsp_data = 6'd33;
        send(1, 1, 1, 0, 6'd20, 6'd0, 6'd8, 0, st1, rq1, we, rb1);
        rsp_data = 6'd44;
        send(1, 1, 1, 0, 6'd21, 6'd0, 6'd9, 0, st2, rq2, we, rb2);
        rsp_data = 6'd0;
        send(1, 1, 0, 0, 6'd5, 6'd0, 6'd10, 0, st3, rq3, we, rb3);
        total++;
        if (st1 !== 1 || st2 !== 1 || rq1 !== 1 || rq2 !== 1) begin
            bad++;
            $display("FAIL b2b_loads: got stalls=%0d,%0d reqs=%0d,%0d, required 1,1 1,1",
                     st1, st2, rq1, rq2);
        end
        total++;
        if (rb1 !== 0 || rb2 !== 0 || st3 !== 0 || rq3 !== 0) begin
            bad++;
            $display("FAIL b2b_tail: got addr_errs=%0d,%0d alu_stalls=%0d alu_reqs=%0d, required 0,0 0 0",
                     rb1, rb2, st3, rq3);
        end
        idle();
    endtask

    task automatic test_reset_mid_access();
        int st, rq, we, rb;
        ack_lat = 0;
        @(posedge clk); #1;
        valid_in = 1; RegWriteIN = 1; MemtoRegIN = 1; MemWriteIN = 0;
        ALUIN = 6'd15; WriteDataIN = 0; WriteRegIN = 6'd4;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b1 || stall_o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre: got req=%0b stall=%0b, required 1 1", mem_req, stall_o);
        end
        #1 rst_n = 0;
        #1;
        total++;
        if ({stall_o, mem_req, mem_we, mem_addr, mem_wdata, valid_out, RegWriteOUT,
             MemtoRegOUT, ReadDataOUT, ALUOUT, WriteRegOUT, err_o} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got req=%0b stall=%0b addr=%0d, required all 0",
                     mem_req, stall_o, mem_addr);
        end
        valid_in = 0; RegWriteIN = 0; MemtoRegIN = 0; ALUIN = 0; WriteRegIN = 0;
        @(negedge clk); rst_n = 1;
        send(1, 1, 0, 0, 6'd11, 6'd0, 6'd7, 0, st, rq, we, rb);
        total++;
        if (st !== 0 || rq !== 0) begin
            bad++;
            $display("FAIL midreset_idle: got stalls=%0d reqs=%0d, required 0 0", st, rq);
        end
        idle();
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        int st, rq, we, rb;
        ack_lat = 0;
        send(1, 1, 1, 0, 6'd40, 6'd0, 6'd12, 1, st, rq, we, rb);
        total++;
        if (st !== 15 || rq !== 15) begin
            bad++;
            $display("FAIL timeout_len: got stalls=%0d reqs=%0d, required 15 15", st, rq);
        end
        idle();
        @(negedge clk); #1;
        total++;
        if (mem_req !== 1'b0 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err: got req=%0b err=%0b, required 0 1", mem_req, err_o);
        end
        repeat (5) @(negedge clk);
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got err=%0b, required 1", err_o);
        end
`else
        repeat (2) @(negedge clk);
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_tied: got err=%0b, required 0", err_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout();
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending retirements, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
